// File: rtl/speed_ramp_ctrl.sv
// speed_ramp_ctrl: gear-limited target duty, slewed toward by a prescaled fixed-rate ramp
module speed_ramp_ctrl #(
    parameter int TICK_DIV = 100000,
    parameter int STEP     = 10,
    parameter int ACC_RATE = 1,
    parameter int DEC_RATE = 2
) (
    input  logic       clk_100mhz,
    input  logic       rst_n,
    input  logic       accel_pulse,
    input  logic       decel_pulse,
    input  logic [2:0] gear_sw,
    output logic [6:0] target_duty,
    output logic [6:0] duty,
    output logic [1:0] state,
    output logic       at_target
);
    localparam logic [16:0] TICK_LAST = 17'(TICK_DIV - 1);
    localparam logic [7:0]  STEP_W    = 8'(STEP);
    localparam logic [6:0]  STEP7     = 7'(STEP);
    localparam logic [6:0]  ACC_W     = 7'(ACC_RATE);
    localparam logic [6:0]  DEC_W     = 7'(DEC_RATE);
    localparam logic [1:0]  IDLE = 2'd0, ACCEL = 2'd1, CRUISE = 2'd2, DECEL = 2'd3;

    logic [6:0]  gmax, target_nxt, duty_nxt, up_gap, dn_gap;
    logic [7:0]  sum;
    logic [16:0] cnt;
    logic        tick;
    logic [1:0]  state_nxt;

    always_comb begin
        gmax = (gear_sw >= 3'd1 && gear_sw <= 3'd5) ? 7'(gear_sw) * 7'd20 : 7'd0;
        sum  = {1'b0, target_duty} + STEP_W;
        // clamp to the gear limit wins over any pulse arriving in the same cycle
        target_nxt = target_duty > gmax ? gmax
                   : accel_pulse && !decel_pulse ? (sum > {1'b0, gmax} ? gmax : sum[6:0])
                   : decel_pulse && !accel_pulse ? (target_duty >= STEP7 ? target_duty - STEP7 : 7'd0)
                   : target_duty;
    end

    assign tick = cnt == TICK_LAST;

    always_comb begin
        up_gap   = target_duty - duty;
        dn_gap   = duty - target_duty;
        duty_nxt = !tick ? duty
                 : duty < target_duty ? duty + (up_gap < ACC_W ? up_gap : ACC_W)
                 : duty > target_duty ? duty - (dn_gap < DEC_W ? dn_gap : DEC_W)
                 : duty;
    end

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) begin
            target_duty <= 7'd0;
            duty        <= 7'd0;
            cnt         <= 17'd0;
        end else begin
            target_duty <= target_nxt;
            duty        <= duty_nxt;
            cnt         <= tick ? 17'd0 : cnt + 17'd1;
        end
    end

    always_ff @(posedge clk_100mhz or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = duty < target_duty ? ACCEL
                  : duty > target_duty ? DECEL
                  : duty == 7'd0 ? IDLE
                  : CRUISE;
    end

    always_comb begin
        at_target = state == IDLE || state == CRUISE;
    end
endmodule
